// File: rtl/trigger_pkg.sv
// Shared definitions for the trigger sequencer.
//   - Operator and value-select encodings of the 6-bit per-channel op field
//   - Slice positions inside that field
//   - FSM state encoding
package trigger_pkg;

    // Operator codes (op field bits [5:3])
    localparam logic [2:0] OP_EQ  = 3'd0;
    localparam logic [2:0] OP_NEQ = 3'd1;
    localparam logic [2:0] OP_LT  = 3'd2;
    localparam logic [2:0] OP_LTE = 3'd3;
    localparam logic [2:0] OP_GT  = 3'd4;
    localparam logic [2:0] OP_GTE = 3'd5;

    // Value-select codes (op field bits [2:0])
    localparam logic [2:0] VAL_LOGIC0 = 3'd0;  // bit mode: level 0
    localparam logic [2:0] VAL_LOGIC1 = 3'd1;  // bit mode: level 1
    localparam logic [2:0] VAL_X      = 3'd2;  // don't care, always matches
    localparam logic [2:0] VAL_RISE   = 3'd3;  // bit mode: rising edge
    localparam logic [2:0] VAL_FALL   = 3'd4;  // bit mode: falling edge
    localparam logic [2:0] VAL_BOTH   = 3'd5;  // bit mode: any edge
    localparam logic [2:0] VAL_NONE   = 3'd6;  // bit mode: no edge
    localparam logic [2:0] VAL_NUM    = 3'd7;  // word mode: numeric compare

    // Layout of one per-stage/per-channel op field
    localparam int OP_FIELD_W   = 6;
    localparam int OP_FIELD_OP  = 3;   // lsb of operator slice
    localparam int OP_FIELD_VAL = 0;   // lsb of value-select slice

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/trig_chan_cmp.sv
// Single-channel comparator for the trigger sequencer.
//   in_q   : current registered sample of the channel
//   in_qq  : previous sample (used for edge detection in bit mode)
//   op     : {operator[2:0], value_sel[2:0]}
//   value  : compare value (word mode only)
//   match  : channel condition satisfied this cycle
// WIDTH == 1 selects bit mode (levels/edges), WIDTH > 1 selects word mode
// (unsigned numeric compare).
module trig_chan_cmp
    import trigger_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]      in_q,
    input  logic [WIDTH-1:0]      in_qq,
    input  logic [OP_FIELD_W-1:0] op,
    input  logic [WIDTH-1:0]      value,
    output logic                  match
);

    logic [2:0] oper;
    logic [2:0] vsel;

    assign oper = op[OP_FIELD_OP  +: 3];
    assign vsel = op[OP_FIELD_VAL +: 3];

    generate
        if (WIDTH == 1) begin : g_bit
            // Compare value has no meaning for a single bit channel.
            logic unused_value;
            assign unused_value = ^value;

            always_comb begin
                match = 1'b0;
                // Only EQ is a legal operator in bit mode.
                if (oper == OP_EQ) begin
                    case (vsel)
                        VAL_LOGIC0: match = ~in_q[0];
                        VAL_LOGIC1: match = in_q[0];
                        VAL_X:      match = 1'b1;
                        VAL_RISE:   match = in_q[0] & ~in_qq[0];
                        VAL_FALL:   match = ~in_q[0] & in_qq[0];
                        VAL_BOTH:   match = in_q[0] ^ in_qq[0];
                        VAL_NONE:   match = ~(in_q[0] ^ in_qq[0]);
                        default:    match = 1'b0;
                    endcase
                end
            end
        end else begin : g_word
            // Edges are not defined for word channels.
            logic unused_prev;
            assign unused_prev = ^in_qq;

            always_comb begin
                match = 1'b0;
                case (vsel)
                    VAL_X: match = 1'b1;
                    VAL_NUM: begin
                        case (oper)
                            OP_EQ:   match = (in_q == value);
                            OP_NEQ:  match = (in_q != value);
                            OP_LT:   match = (in_q <  value);
                            OP_LTE:  match = (in_q <= value);
                            OP_GT:   match = (in_q >  value);
                            OP_GTE:  match = (in_q >= value);
                            default: match = 1'b0;
                        endcase
                    end
                    default: match = 1'b0;
                endcase
            end
        end
    endgenerate

endmodule

// File: rtl/trigger_sequencer.sv
// Multi-channel, multi-stage trigger engine.
//   clk, rst     : clock and synchronous active-high reset
//   arm, abort   : start/restart a run; cancel a run (abort wins)
//   in           : probe data, channel c at [c*WIDTH +: WIDTH]
//   cfg_*        : per-stage configuration, latched when a run is armed
//   trig         : one-cycle pulse when the final stage completes
//   triggered    : high while in DONE
//   armed        : high while in RUN
//   stage        : current stage index
module trigger_sequencer
    import trigger_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int CH_NUM = 4,
    parameter int STAGES = 4,
    parameter int CNT_W  = 16,
    parameter int SW     = (STAGES > 1) ? $clog2(STAGES) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 arm,
    input  logic                                 abort,
    input  logic [CH_NUM*WIDTH-1:0]              in,
    input  logic [STAGES*CH_NUM*OP_FIELD_W-1:0]  cfg_op,
    input  logic [STAGES*CH_NUM*WIDTH-1:0]       cfg_value,
    input  logic [STAGES*CH_NUM-1:0]             cfg_mask,
    input  logic [STAGES-1:0]                    cfg_logic,
    input  logic [STAGES*CNT_W-1:0]              cfg_count,
    input  logic [STAGES-1:0]                    cfg_consec,
    input  logic [SW-1:0]                        cfg_last,
    output logic                                 trig,
    output logic                                 triggered,
    output logic                                 armed,
    output logic [SW-1:0]                        stage
);

    localparam int STG_OP_W  = CH_NUM * OP_FIELD_W;
    localparam int STG_VAL_W = CH_NUM * WIDTH;

    state_t             state_reg, state_next;
    logic [SW-1:0]      stage_reg, stage_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               trig_reg, trig_next;
    logic               load_cfg;

    logic [CH_NUM*WIDTH-1:0] in_q, in_qq;

    // Configuration snapshot taken when a run is armed
    logic [STAGES*CH_NUM*OP_FIELD_W-1:0] cfg_op_reg;
    logic [STAGES*CH_NUM*WIDTH-1:0]      cfg_value_reg;
    logic [STAGES*CH_NUM-1:0]            cfg_mask_reg;
    logic [STAGES-1:0]                   cfg_logic_reg;
    logic [STAGES*CNT_W-1:0]             cfg_count_reg;
    logic [STAGES-1:0]                   cfg_consec_reg;
    logic [SW-1:0]                       last_reg;
    logic [SW-1:0]                       last_clamped;

    // Current stage's slice of the snapshot
    logic [STG_OP_W-1:0]  stg_op;
    logic [STG_VAL_W-1:0] stg_value;
    logic [CH_NUM-1:0]    stg_mask;
    logic                 stg_logic;
    logic [CNT_W-1:0]     stg_count;
    logic                 stg_consec;

    logic [CH_NUM-1:0]    match;
    logic                 cond;
    logic [CNT_W-1:0]     need;
    logic [CNT_W:0]       cnt_inc;
    logic                 reached;

    assign stg_op     = cfg_op_reg[stage_reg*STG_OP_W +: STG_OP_W];
    assign stg_value  = cfg_value_reg[stage_reg*STG_VAL_W +: STG_VAL_W];
    assign stg_mask   = cfg_mask_reg[stage_reg*CH_NUM +: CH_NUM];
    assign stg_logic  = cfg_logic_reg[stage_reg];
    assign stg_count  = cfg_count_reg[stage_reg*CNT_W +: CNT_W];
    assign stg_consec = cfg_consec_reg[stage_reg];

    // Out-of-range final stage index is pulled back to the last real stage.
    always_comb begin
        last_clamped = cfg_last;
        if ({1'b0, cfg_last} >= (SW+1)'(STAGES))
            last_clamped = SW'(STAGES - 1);
    end

    genvar gi;
    generate
        for (gi = 0; gi < CH_NUM; gi++) begin : g_chan
            trig_chan_cmp #(
                .WIDTH (WIDTH)
            ) u_cmp (
                .in_q  (in_q[gi*WIDTH +: WIDTH]),
                .in_qq (in_qq[gi*WIDTH +: WIDTH]),
                .op    (stg_op[gi*OP_FIELD_W +: OP_FIELD_W]),
                .value (stg_value[gi*WIDTH +: WIDTH]),
                .match (match[gi])
            );
        end
    endgenerate

    // Masked-out channels are neutral; a stage with no enabled channel is
    // unconditionally true in both AND and OR mode.
    always_comb begin
        if (stg_mask == '0)
            cond = 1'b1;
        else if (stg_logic)
            cond = |(match & stg_mask);
        else
            cond = &(match | ~stg_mask);
    end

    // A zero occurrence count behaves as one.
    assign need    = (stg_count == '0) ? CNT_W'(1) : stg_count;
    assign cnt_inc = {1'b0, cnt_reg} + (CNT_W+1)'(1);
    assign reached = (cnt_inc >= {1'b0, need});

    always_comb begin
        state_next = state_reg;
        stage_next = stage_reg;
        cnt_next   = cnt_reg;
        trig_next  = 1'b0;
        load_cfg   = 1'b0;

        if (abort) begin
            state_next = ST_IDLE;
            stage_next = '0;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        state_next = ST_RUN;
                        stage_next = '0;
                        cnt_next   = '0;
                        load_cfg   = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (cond) begin
                        if (reached) begin
                            cnt_next = '0;
                            if (stage_reg == last_reg) begin
                                state_next = ST_DONE;
                                trig_next  = 1'b1;
                            end else begin
                                stage_next = stage_reg + SW'(1);
                            end
                        end else begin
                            cnt_next = cnt_inc[CNT_W-1:0];
                        end
                    end else if (stg_consec) begin
                        cnt_next = '0;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    stage_next = '0;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            stage_reg      <= '0;
            cnt_reg        <= '0;
            trig_reg       <= 1'b0;
            in_q           <= '0;
            in_qq          <= '0;
            cfg_op_reg     <= '0;
            cfg_value_reg  <= '0;
            cfg_mask_reg   <= '0;
            cfg_logic_reg  <= '0;
            cfg_count_reg  <= '0;
            cfg_consec_reg <= '0;
            last_reg       <= '0;
        end else begin
            in_q      <= in;
            in_qq     <= in_q;
            state_reg <= state_next;
            stage_reg <= stage_next;
            cnt_reg   <= cnt_next;
            trig_reg  <= trig_next;
            if (load_cfg) begin
                cfg_op_reg     <= cfg_op;
                cfg_value_reg  <= cfg_value;
                cfg_mask_reg   <= cfg_mask;
                cfg_logic_reg  <= cfg_logic;
                cfg_count_reg  <= cfg_count;
                cfg_consec_reg <= cfg_consec;
                last_reg       <= last_clamped;
            end
        end
    end

    assign trig      = trig_reg;
    assign triggered = (state_reg == ST_DONE);
    assign armed     = (state_reg == ST_RUN);
    assign stage     = stage_reg;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Directed bench: one word-mode instance (A) and one bit-mode instance (B).
module tb_trigger_sequencer;
    import trigger_pkg::*;

    localparam int W   = 8;
    localparam int CH  = 2;
    localparam int ST  = 2;
    localparam int CW  = 16;
    localparam int SWL = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: word mode
    logic                  a_arm, a_abort;
    logic [CH*W-1:0]       a_in;
    logic [ST*CH*6-1:0]    a_op;
    logic [ST*CH*W-1:0]    a_val;
    logic [ST*CH-1:0]      a_mask;
    logic [ST-1:0]         a_logic;
    logic [ST*CW-1:0]      a_cnt;
    logic [ST-1:0]         a_consec;
    logic [SWL-1:0]        a_last;
    logic                  a_trig, a_triggered, a_armed;
    logic [SWL-1:0]        a_stage;

    // Instance B: bit mode
    logic                  b_arm, b_abort;
    logic [CH-1:0]         b_in;
    logic [ST*CH*6-1:0]    b_op;
    logic [ST*CH-1:0]      b_val;
    logic [ST*CH-1:0]      b_mask;
    logic [ST-1:0]         b_logic;
    logic [ST*CW-1:0]      b_cnt;
    logic [ST-1:0]         b_consec;
    logic [SWL-1:0]        b_last;
    logic                  b_trig, b_triggered, b_armed;
    logic [SWL-1:0]        b_stage;

    trigger_sequencer #(.WIDTH(W), .CH_NUM(CH), .STAGES(ST), .CNT_W(CW)) u_a (
        .clk(clk), .rst(rst), .arm(a_arm), .abort(a_abort), .in(a_in),
        .cfg_op(a_op), .cfg_value(a_val), .cfg_mask(a_mask), .cfg_logic(a_logic),
        .cfg_count(a_cnt), .cfg_consec(a_consec), .cfg_last(a_last),
        .trig(a_trig), .triggered(a_triggered), .armed(a_armed), .stage(a_stage)
    );

    trigger_sequencer #(.WIDTH(1), .CH_NUM(CH), .STAGES(ST), .CNT_W(CW)) u_b (
        .clk(clk), .rst(rst), .arm(b_arm), .abort(b_abort), .in(b_in),
        .cfg_op(b_op), .cfg_value(b_val), .cfg_mask(b_mask), .cfg_logic(b_logic),
        .cfg_count(b_cnt), .cfg_consec(b_consec), .cfg_last(b_last),
        .trig(b_trig), .triggered(b_triggered), .armed(b_armed), .stage(b_stage)
    );

    int tests    = 0;
    int failures = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    logic [5:0] pat6;
    logic [4:0] pat5;

    initial begin
        a_arm = 0; a_abort = 0; a_in = '0;
        a_op = '0; a_val = '0; a_mask = '0; a_logic = '0;
        a_cnt = '0; a_consec = '0; a_last = '0;
        b_arm = 0; b_abort = 0; b_in = '0;
        b_op = '0; b_val = '0; b_mask = '0; b_logic = '0;
        b_cnt = '0; b_consec = '0; b_last = '0;

        // ---------------- reset state
        repeat (3) tick();
        chk("rst_a_trig", a_trig, 1'b0);
        chk("rst_a_triggered", a_triggered, 1'b0);
        chk("rst_a_armed", a_armed, 1'b0);
        chk("rst_a_stage", a_stage[0], 1'b0);
        chk("rst_b_trig", b_trig, 1'b0);
        chk("rst_b_triggered", b_triggered, 1'b0);
        chk("rst_b_armed", b_armed, 1'b0);
        chk("rst_b_stage", b_stage[0], 1'b0);
        rst = 0;
        tick();

        // ---------------- A: single stage ch0 == 0x55, ch1 masked
        a_op[0 +: 6]  = {OP_EQ, VAL_NUM};
        a_val[0 +: 8] = 8'h55;
        a_mask = 4'b0001;
        a_cnt[0 +: 16] = 16'd1;
        a_arm = 1; tick(); a_arm = 0;
        chk("eq_armed", a_armed, 1'b1);
        a_in = 16'h5512; tick(); tick();
        chk("eq_no_trig", a_trig, 1'b0);
        a_in = 16'h0055; tick();
        chk("eq_latency", a_trig, 1'b0);
        a_in = 16'h0000; tick();
        chk("eq_trig", a_trig, 1'b1);
        chk("eq_triggered", a_triggered, 1'b1);
        chk("eq_armed_low", a_armed, 1'b0);
        tick();
        chk("eq_trig_pulse", a_trig, 1'b0);
        chk("eq_triggered_hold", a_triggered, 1'b1);

        // ---------------- A: OR of ch0 > 0x80, ch1 < 0x10
        a_op[0 +: 6]  = {OP_GT, VAL_NUM}; a_val[0 +: 8] = 8'h80;
        a_op[6 +: 6]  = {OP_LT, VAL_NUM}; a_val[8 +: 8] = 8'h10;
        a_mask = 4'b0011; a_logic[0] = 1'b1;
        a_in = {8'hFF, 8'h00};
        a_arm = 1; tick(); a_arm = 0;
        chk("or_rearm_clear", a_triggered, 1'b0);
        a_in = {8'h10, 8'h80}; tick(); tick();
        chk("or_bounds_no_trig", a_trig, 1'b0);
        a_in = {8'h0F, 8'h80}; tick(); tick();
        chk("or_trig", a_trig, 1'b1);

        // ---------------- A: AND of ch0 >= 0x80, ch1 < 0x10
        a_op[0 +: 6] = {OP_GTE, VAL_NUM}; a_logic[0] = 1'b0;
        a_in = {8'hFF, 8'h00};
        a_arm = 1; tick(); a_arm = 0;
        a_in = {8'h0F, 8'h7F}; tick(); tick();
        chk("and_partial_no_trig", a_trig, 1'b0);
        a_in = {8'h0F, 8'h80}; tick(); tick();
        chk("and_trig", a_trig, 1'b1);

        // ---------------- A: count=3 consecutive, pattern T,T,F,T,T,T
        a_op[0 +: 6] = {OP_EQ, VAL_NUM}; a_val[0 +: 8] = 8'h55;
        a_mask = 4'b0001; a_cnt[0 +: 16] = 16'd3; a_consec[0] = 1'b1;
        a_in = '0;
        a_arm = 1; tick(); a_arm = 0;
        pat6 = 6'b111011;
        for (int i = 0; i < 6; i++) begin
            a_in = pat6[i] ? 16'h0055 : 16'h0000;
            tick();
            chk("consec_wait", a_trig, 1'b0);
        end
        a_in = '0; tick();
        chk("consec_trig", a_trig, 1'b1);

        // ---------------- A: count=3 non-consecutive, pattern T,F,T,F,T
        a_consec[0] = 1'b0;
        a_arm = 1; tick(); a_arm = 0;
        pat5 = 5'b10101;
        for (int i = 0; i < 5; i++) begin
            a_in = pat5[i] ? 16'h0055 : 16'h0000;
            tick();
            chk("nonconsec_wait", a_trig, 1'b0);
        end
        a_in = '0; tick();
        chk("nonconsec_trig", a_trig, 1'b1);

        // ---------------- A: config change after arm has no effect
        a_cnt[0 +: 16] = 16'd1;
        a_arm = 1; tick(); a_arm = 0;
        a_val[0 +: 8] = 8'hAA;
        a_in = 16'h0055; tick(); tick();
        chk("cfg_held_trig", a_trig, 1'b1);
        a_in = '0;
        a_arm = 1; tick(); a_arm = 0;
        a_in = 16'h0055; tick(); tick();
        chk("cfg_relatch_no_trig", a_trig, 1'b0);
        tick();
        chk("cfg_relatch_no_trig2", a_trig, 1'b0);
        chk("cfg_relatch_armed", a_armed, 1'b1);
        a_in = 16'h00AA; tick(); tick();
        chk("cfg_relatch_trig", a_trig, 1'b1);

        // ---------------- A: all channels masked
        a_mask = 4'b0000; a_in = '0;
        a_arm = 1; tick(); a_arm = 0;
        chk("masked_armed", a_armed, 1'b1);
        chk("masked_no_trig_yet", a_trig, 1'b0);
        tick();
        chk("masked_trig", a_trig, 1'b1);

        // ---------------- B: stage0 ch0 rise, stage1 ch1 fall (count 0 -> 1)
        b_op[0 +: 6]  = {OP_EQ, VAL_RISE};
        b_op[18 +: 6] = {OP_EQ, VAL_FALL};
        b_mask = 4'b1001;
        b_cnt[0 +: 16] = 16'd1; b_cnt[16 +: 16] = 16'd0;
        b_last = 1'b1;
        b_in = 2'b10;
        b_arm = 1; tick(); b_arm = 0;
        tick();
        b_in = 2'b00; tick();               // ch1 falls while in stage 0
        chk("seq_s0_hold", b_stage[0], 1'b0);
        tick();
        b_in = 2'b01; tick();               // ch0 rises
        chk("seq_s0_eval", b_stage[0], 1'b0);
        chk("seq_no_early_trig", b_trig, 1'b0);
        b_in = 2'b11; tick();
        chk("seq_stage1", b_stage[0], 1'b1);
        tick();
        b_in = 2'b01; tick();               // ch1 falls
        chk("seq_wait_trig", b_trig, 1'b0);
        tick();
        chk("seq_trig", b_trig, 1'b1);
        chk("seq_triggered", b_triggered, 1'b1);

        // ---------------- B: abort in stage 1
        b_arm = 1; tick(); b_arm = 0;
        b_in = 2'b00; tick();
        b_in = 2'b01; tick(); tick();
        chk("abort_pre_stage1", b_stage[0], 1'b1);
        b_abort = 1; tick(); b_abort = 0;
        chk("abort_armed", b_armed, 1'b0);
        chk("abort_stage", b_stage[0], 1'b0);
        chk("abort_trig", b_trig, 1'b0);
        b_in = 2'b11; tick();
        b_in = 2'b01; tick(); tick(); tick();
        chk("abort_no_trig", b_trig, 1'b0);
        chk("abort_not_triggered", b_triggered, 1'b0);

        // ---------------- B: arm and abort together in IDLE
        b_arm = 1; b_abort = 1; tick(); b_arm = 0; b_abort = 0;
        chk("arm_abort_idle", b_armed, 1'b0);

        // ---------------- B: reset mid-run
        b_in = 2'b00;
        b_arm = 1; tick(); b_arm = 0;
        b_in = 2'b01; tick(); tick();
        chk("rst_run_stage1", b_stage[0], 1'b1);
        rst = 1; tick(); rst = 0;
        chk("rst_run_trig", b_trig, 1'b0);
        chk("rst_run_triggered", b_triggered, 1'b0);
        chk("rst_run_armed", b_armed, 1'b0);
        chk("rst_run_stage", b_stage[0], 1'b0);
        b_in = 2'b10; tick(); tick();
        chk("rst_run_stays_idle", b_armed, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
